// File: rtl/mem_hs_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_hs_controller : multi-cycle RV32I control FSM with req/ack handshakes
//                     to variable-latency instruction and data memories
// Revision          : 1.0
// ============================================================================
module mem_hs_controller #(
   parameter int REG_WIDTH       = 32,
   parameter int TIMEOUT_CYCLES  = 255,
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [REG_WIDTH-1:0] inst_i,
   input  logic                 imem_ack_i,
   input  logic                 dmem_ack_i,
   output logic                 imem_req_o,
   output logic                 dmem_req_o,
   output logic [REG_WIDTH-1:0] inst_o,
   output logic [6:0]           op_o,
   output logic [4:0]           rs1_addr_o,
   output logic [4:0]           rs2_addr_o,
   output logic [4:0]           rd_addr_o,
   output logic                 pc_en_o,
   output logic                 branch_o,
   output logic [2:0]           branch_op_o,
   output logic [1:0]           result_mux_o,
   output logic                 alu_src_a_o,
   output logic                 alu_src_b_o,
   output logic [5:0]           alu_op_o,
   output logic                 mem_write_o,
   output logic                 reg_write_o,
   output logic                 halt_o,
   output logic [1:0]           trap_cause_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

   // ALU ops are {2'b00, alt, funct3}; alt selects SUB/SRA
   localparam logic [5:0] c_ALU_ADD         = 6'd0;
   localparam logic [2:0] c_BRANCH_JAL_JALR = 3'b010;

   localparam logic [1:0] c_CAUSE_NONE    = 2'b00;
   localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] c_CAUSE_SYSTEM  = 2'b10;
   localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b11;

   localparam logic [2:0] c_FETCH = 3'd0;
   localparam logic [2:0] c_EXE   = 3'd1;
   localparam logic [2:0] c_MEM   = 3'd2;
   localparam logic [2:0] c_WB    = 3'd3;
   localparam logic [2:0] c_HALT  = 3'd4;

   localparam int                c_WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]           r_state;
   logic [REG_WIDTH-1:0] r_inst;
   logic [c_WAIT_W-1:0]  r_wait;
   logic [1:0]           r_cause;
   logic [CNT_WIDTH-1:0] r_instret;

   logic [2:0] w_next_state;
   logic [1:0] w_next_cause;
   logic [6:0] w_op;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_alt, w_r_ok, w_shift_ok, w_illegal, w_is_store;
   logic       w_wait_active, w_ack, w_timeout;
   logic       w_imem_req, w_dmem_req, w_pc_en, w_branch, w_src_a, w_src_b;
   logic       w_mem_write, w_reg_write;
   logic [2:0] w_branch_op;
   logic [1:0] w_result_mux;
   logic [5:0] w_alu_op;

   assign w_op       = r_inst[6:0];
   assign w_f3       = r_inst[14:12];
   assign w_f7       = r_inst[31:25];
   assign w_is_store = (w_op == c_OP_STORE);
   assign w_alt      = (w_op == c_OP_R) ? w_f7[5] : ((w_f3 == 3'b101) && w_f7[5]);
   assign w_r_ok     = (w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
   assign w_shift_ok = (w_f3 == 3'b001) ? (w_f7 == 7'h00) :
                       (w_f3 == 3'b101) ? ((w_f7 == 7'h00) || (w_f7 == 7'h20)) : 1'b1;
   assign w_illegal  = !(((w_op == c_OP_R) && w_r_ok) || ((w_op == c_OP_IMM) && w_shift_ok) ||
                         (w_op inside {c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_BRANCH,
                                       c_OP_LOAD, c_OP_STORE, c_OP_FENCE, c_OP_SYSTEM}));

   always_comb begin
      w_next_state  = r_state;
      w_next_cause  = r_cause;
      w_wait_active = 1'b0;
      w_ack         = 1'b0;
      w_timeout     = 1'b0;
      w_imem_req    = 1'b0;
      w_dmem_req    = 1'b0;
      w_pc_en       = 1'b0;
      w_branch      = 1'b0;
      w_branch_op   = 3'b000;
      w_result_mux  = 2'b00;
      w_src_a       = 1'b0;
      w_src_b       = 1'b0;
      w_alu_op      = c_ALU_ADD;
      w_mem_write   = 1'b0;
      w_reg_write   = 1'b0;
      case (r_state)
         c_FETCH: begin
            w_imem_req    = 1'b1;
            w_wait_active = 1'b1;
            w_ack         = imem_ack_i;
            if (imem_ack_i) w_next_state = c_EXE;
         end
         c_EXE, c_MEM: begin
            if (w_illegal) begin
               if (TRAP_ON_ILLEGAL) begin
                  w_next_state = c_HALT;
                  w_next_cause = c_CAUSE_ILLEGAL;
               end else begin
                  w_pc_en      = 1'b1;
                  w_next_state = c_FETCH;
               end
            end else if (w_op == c_OP_SYSTEM) begin
               w_next_state = c_HALT;
               w_next_cause = c_CAUSE_SYSTEM;
            end else if ((w_op == c_OP_LOAD) || w_is_store) begin
               w_dmem_req    = 1'b1;
               w_src_b       = 1'b1;
               w_mem_write   = w_is_store;
               w_wait_active = 1'b1;
               w_ack         = dmem_ack_i;
               if (!dmem_ack_i)     w_next_state = c_MEM;
               else if (w_is_store) begin
                  w_pc_en      = 1'b1;
                  w_next_state = c_FETCH;
               end else             w_next_state = c_WB;
            end else begin
               w_pc_en      = 1'b1;
               w_next_state = c_FETCH;
               case (w_op)
                  c_OP_R: begin
                     w_reg_write = 1'b1;
                     w_alu_op    = {2'b00, w_alt, w_f3};
                  end
                  c_OP_IMM: begin
                     w_reg_write = 1'b1;
                     w_src_b     = 1'b1;
                     w_alu_op    = {2'b00, w_alt, w_f3};
                  end
                  c_OP_LUI: begin
                     w_reg_write = 1'b1;
                     w_src_b     = 1'b1;
                  end
                  c_OP_AUIPC: begin
                     w_reg_write = 1'b1;
                     w_src_a     = 1'b1;
                     w_src_b     = 1'b1;
                  end
                  c_OP_JAL, c_OP_JALR: begin
                     w_reg_write  = 1'b1;
                     w_result_mux = 2'b01;
                     w_branch     = 1'b1;
                     w_branch_op  = c_BRANCH_JAL_JALR;
                     w_src_a      = (w_op == c_OP_JAL);
                     w_src_b      = 1'b1;
                  end
                  c_OP_BRANCH: begin
                     w_branch    = 1'b1;
                     w_branch_op = w_f3;
                     w_src_a     = 1'b1;
                     w_src_b     = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         c_WB: begin
            w_result_mux = 2'b10;
            w_reg_write  = 1'b1;
            w_pc_en      = 1'b1;
            w_next_state = c_FETCH;
         end
         default: ;
      endcase
      // An ack on the deadline edge still wins because the check needs ack low
      if ((TIMEOUT_CYCLES != 0) && w_wait_active && !w_ack && (r_wait == c_WAIT_LAST)) begin
         w_timeout    = 1'b1;
         w_next_state = c_HALT;
         w_next_cause = c_CAUSE_TIMEOUT;
      end
   end

   // EXE->MEM continues the same data wait rather than restarting it
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= c_FETCH;
         r_inst    <= '0;
         r_wait    <= '0;
         r_cause   <= c_CAUSE_NONE;
         r_instret <= '0;
      end else begin
         r_state   <= w_next_state;
         r_cause   <= w_next_cause;
         r_instret <= r_instret + {{(CNT_WIDTH-1){1'b0}}, w_pc_en};
         if ((r_state == c_FETCH) && imem_ack_i) r_inst <= inst_i;
         if (w_wait_active && !w_ack && !w_timeout) r_wait <= r_wait + 1'b1;
         else                                       r_wait <= '0;
      end
   end

   assign imem_req_o   = w_imem_req;
   assign dmem_req_o   = w_dmem_req;
   assign inst_o       = r_inst;
   assign op_o         = w_op;
   assign rs1_addr_o   = (w_op == c_OP_LUI) ? 5'd0 : r_inst[19:15];
   assign rs2_addr_o   = r_inst[24:20];
   assign rd_addr_o    = r_inst[11:7];
   assign pc_en_o      = w_pc_en;
   assign branch_o     = w_branch;
   assign branch_op_o  = w_branch_op;
   assign result_mux_o = w_result_mux;
   assign alu_src_a_o  = w_src_a;
   assign alu_src_b_o  = w_src_b;
   assign alu_op_o     = w_alu_op;
   assign mem_write_o  = w_mem_write;
   assign reg_write_o  = w_reg_write;
   assign halt_o       = (r_state == c_HALT);
   assign trap_cause_o = r_cause;
   assign instret_o    = r_instret;

endmodule
`default_nettype wire
